// File: rtl/or1200_keccak_ctrl.sv
// Sequencer between the OR1200 l.cust5 ALU path and a Keccak-f[1600] core: packs message
// words into the rate buffer, pads the final block, stalls the CPU and returns the digest.
module or1200_keccak_ctrl #(
    parameter int unsigned RATE_WORDS   = 18,
    parameter int unsigned DIGEST_WORDS = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cust5_valid,
    input  logic [4:0]                cust5_op,
    input  logic [5:0]                cust5_limm,
    input  logic [31:0]               operand_a,
    output logic                      stall,
    output logic [31:0]               result,
    output logic [32*RATE_WORDS-1:0]  blk_data,
    output logic                      blk_valid,
    output logic                      blk_last,
    input  logic                      blk_ready,
    input  logic                      core_done,
    input  logic [32*DIGEST_WORDS-1:0] digest
);

    localparam int unsigned BufW = 32 * RATE_WORDS;
    localparam int unsigned DigW = 32 * DIGEST_WORDS;
    localparam int unsigned CntW = $clog2(RATE_WORDS + 1);
    localparam int unsigned PosW = $clog2(4 * RATE_WORDS);

    typedef enum logic [2:0] {
        StIdle, StAbsorb, StSend, StPerm, StSendLast, StPermLast, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BufW-1:0]   buf_q, buf_d;
    logic [DigW-1:0]   dig_q, dig_d;
    logic [PosW-1:0]   tail_pos;
    logic [31:0]       op_le;
    logic [1:0]        tail_n;
    logic              is_head, is_data, is_tail, is_store;
    logic              busy, busy_last, accept, start;
    logic              limm_unused;

    assign is_head  = (cust5_op == 5'b00100);
    assign is_data  = (cust5_op == 5'b00010);
    assign is_tail  = (cust5_op == 5'b00001);
    assign is_store = (cust5_op == 5'b01000);
    assign tail_n   = cust5_limm[1:0];
    assign limm_unused = ^cust5_limm[5:4];

    // First message byte sits in operand_a[31:24] but is byte 0 of the word in the buffer.
    assign op_le = {operand_a[7:0], operand_a[15:8], operand_a[23:16], operand_a[31:24]};

    assign busy      = (state_q == StSend) || (state_q == StPerm);
    assign busy_last = (state_q == StSendLast) || (state_q == StPermLast);

    assign stall = cust5_valid &&
                   (((is_head || is_data || is_tail) && (busy || busy_last)) ||
                    (is_store && busy_last));
    assign accept = cust5_valid && !stall;
    assign start  = accept && is_head &&
                    (state_q inside {StIdle, StAbsorb, StDone});

    assign blk_data  = buf_q;
    assign blk_valid = (state_q == StSend) || (state_q == StSendLast);
    assign blk_last  = (state_q == StSendLast);
    assign result    = (cust5_valid && is_store && state_q == StDone) ?
                       dig_q[32*cust5_limm[3:0] +: 32] : 32'h0;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        buf_d    = buf_q;
        dig_d    = dig_q;
        tail_pos = '0;
        if (start) begin
            buf_d        = '0;
            buf_d[31:0]  = op_le;
            cnt_d        = CntW'(1);
            state_d      = StAbsorb;
        end else begin
            unique case (state_q)
                StAbsorb: begin
                    if (accept && is_data) begin
                        buf_d[32*cnt_q +: 32] = op_le;
                        if (cnt_q == CntW'(RATE_WORDS - 1)) begin
                            cnt_d   = '0;
                            state_d = StSend;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else if (accept && is_tail) begin
                        if (tail_n > 2'd0) buf_d[32*cnt_q      +: 8] = operand_a[31:24];
                        if (tail_n > 2'd1) buf_d[32*cnt_q + 8  +: 8] = operand_a[23:16];
                        if (tail_n > 2'd2) buf_d[32*cnt_q + 16 +: 8] = operand_a[15:8];
                        // Padding always lands inside this block since count <= RATE_WORDS-1.
                        tail_pos = (PosW'(cnt_q) << 2) + PosW'(tail_n);
                        buf_d[8*tail_pos +: 8] = buf_d[8*tail_pos +: 8] | 8'h06;
                        buf_d[BufW-1 -: 8]     = buf_d[BufW-1 -: 8] | 8'h80;
                        state_d = StSendLast;
                    end
                end
                StSend: begin
                    if (blk_ready) begin
                        buf_d   = '0;
                        state_d = StPerm;
                    end
                end
                StSendLast: begin
                    if (blk_ready) begin
                        buf_d   = '0;
                        state_d = StPermLast;
                    end
                end
                StPerm: begin
                    if (core_done) state_d = StAbsorb;
                end
                StPermLast: begin
                    if (core_done) begin
                        dig_d   = digest;
                        state_d = StDone;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            buf_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dig_q   <= dig_d;
        end
    end

endmodule

// File: tb/tb_or1200_keccak_ctrl.sv
// Scoreboard bench for or1200_keccak_ctrl: a byte-level padding model feeds expected blocks
// and STORE results into queues that a negedge monitor drains.
module tb_or1200_keccak_ctrl;

    localparam int RW = 18;
    localparam int DW = 16;
    localparam logic [4:0] OP_HEAD  = 5'b00100;
    localparam logic [4:0] OP_DATA  = 5'b00010;
    localparam logic [4:0] OP_TAIL  = 5'b00001;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_NOP   = 5'b10000;

    logic              clk, rst;
    logic              cust5_valid;
    logic [4:0]        cust5_op;
    logic [5:0]        cust5_limm;
    logic [31:0]       operand_a;
    logic              stall;
    logic [31:0]       result;
    logic [32*RW-1:0]  blk_data;
    logic              blk_valid, blk_last, blk_ready, core_done;
    logic [32*DW-1:0]  digest, dig_val;

    typedef struct {
        logic [32*RW-1:0] data;
        logic             last;
    } blk_t;

    blk_t          exp_blk[$];
    logic [31:0]   exp_res[$];
    byte unsigned  cur[$];
    blk_t          mon_e;
    logic [31:0]   mon_r;
    int            checks = 0;
    int            errors = 0;
    int            last_stalls;
    bit            core_en;
    int            ready_lat, perm_lat;

    or1200_keccak_ctrl #(.RATE_WORDS(RW), .DIGEST_WORDS(DW)) dut (
        .clk(clk), .rst(rst), .cust5_valid(cust5_valid), .cust5_op(cust5_op),
        .cust5_limm(cust5_limm), .operand_a(operand_a), .stall(stall), .result(result),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
        .blk_ready(blk_ready), .core_done(core_done), .digest(digest)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: message bytes in arrival order, SHA3 pad on the final block.
    task automatic push_word(input logic [31:0] a, input int n);
        for (int b = 0; b < n; b++) cur.push_back(a[31-8*b -: 8]);
    endtask

    task automatic model_block(input bit last);
        blk_t e;
        e.data = '0;
        foreach (cur[k]) e.data[8*k +: 8] = cur[k];
        if (last) begin
            e.data[8*cur.size() +: 8] = e.data[8*cur.size() +: 8] | 8'h06;
            e.data[32*RW-1 -: 8]      = e.data[32*RW-1 -: 8] | 8'h80;
        end
        e.last = last;
        exp_blk.push_back(e);
        cur.delete();
    endtask

    task automatic issue(input logic [4:0] op, input logic [5:0] limm, input logic [31:0] a);
        cust5_valid = 1;
        cust5_op    = op;
        cust5_limm  = limm;
        operand_a   = a;
        last_stalls = 0;
        @(negedge clk);
        while (stall && last_stalls < 300) begin
            last_stalls++;
            @(negedge clk);
        end
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op %b still stalled, want accepted", op);
        end
        step();
        cust5_valid = 0;
        cust5_op    = 5'b0;
        cust5_limm  = 6'b0;
        operand_a   = 32'h0;
    endtask

    task automatic do_head(input logic [31:0] a);
        cur.delete();
        push_word(a, 4);
        issue(OP_HEAD, 6'd0, a);
    endtask

    task automatic do_data(input logic [31:0] a);
        push_word(a, 4);
        if (cur.size() == 4 * RW) model_block(1'b0);
        issue(OP_DATA, 6'd0, a);
    endtask

    task automatic do_tail(input logic [1:0] n, input logic [31:0] a);
        push_word(a, int'(n));
        model_block(1'b1);
        issue(OP_TAIL, {4'd0, n}, a);
    endtask

    task automatic do_store(input logic [3:0] i, input logic [31:0] exp);
        exp_res.push_back(exp);
        issue(OP_STORE, {2'd0, i}, 32'h0);
    endtask

    // Core model: accepts a block after ready_lat cycles, pulses core_done perm_lat later.
    initial begin
        blk_ready = 0;
        core_done = 0;
        digest    = ~dig_val;
        forever begin
            step();
            if (core_en && blk_valid) begin
                repeat (ready_lat) step();
                blk_ready = 1;
                step();
                blk_ready = 0;
                repeat (perm_lat) step();
                core_done = 1;
                digest    = dig_val;
                step();
                core_done = 0;
                digest    = ~dig_val;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && blk_valid && blk_ready) begin
            checks++;
            if (exp_blk.size() == 0) begin
                errors++;
                $display("FAIL block_unexpected: got last=%0b, want no block", blk_last);
            end else begin
                mon_e = exp_blk.pop_front();
                if (blk_data !== mon_e.data || blk_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL block: got last=%0b data=%h, want last=%0b data=%h",
                             blk_last, blk_data, mon_e.last, mon_e.data);
                end
            end
        end
        if (rst && cust5_valid && !stall && cust5_op == OP_STORE) begin
            checks++;
            if (exp_res.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got %h, want no store", result);
            end else begin
                mon_r = exp_res.pop_front();
                if (result !== mon_r) begin
                    errors++;
                    $display("FAIL store_result: got %h, want %h", result, mon_r);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < DW; w++) dig_val[32*w +: 32] = 32'hA0B0C000 | 32'(w);
        rst = 1; cust5_valid = 0; cust5_op = 0; cust5_limm = 0; operand_a = 0;
        core_en = 1; ready_lat = 2; perm_lat = 3;
        #3 rst = 0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_blk_valid", 32'(blk_valid), 32'd0);
        chk("rst_result", result, 32'h0);
        @(posedge clk);
        #1 rst = 1;
        do_store(4'd15, 32'h0);

        cust5_valid = 1; cust5_op = OP_NOP; operand_a = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("nop_stall", 32'(stall), 32'd0);
        chk("nop_result", result, 32'h0);
        step();
        cust5_valid = 0; cust5_op = 0; operand_a = 0;

        // Single block: "The quick brown fox jumps over the lazy dog."
        do_head(32'h54686520);
        do_data(32'h71756963); do_data(32'h6B206272); do_data(32'h6F776E20);
        do_data(32'h666F7820); do_data(32'h6A756D70); do_data(32'h73206F76);
        do_data(32'h65722074); do_data(32'h6865206C); do_data(32'h617A7920);
        do_data(32'h646F672E);
        do_tail(2'd0, 32'h0);
        @(negedge clk);
        chk("single_valid", 32'(blk_valid), 32'd1);
        chk("single_last", 32'(blk_last), 32'd1);
        chk("single_byte0", 32'(blk_data[7:0]), 32'h54);
        chk("single_byte44", 32'(blk_data[8*44 +: 8]), 32'h06);
        chk("single_bytes45_70", 32'(|blk_data[8*45 +: 8*26]), 32'd0);
        chk("single_byte71", 32'(blk_data[8*71 +: 8]), 32'h80);
        step();
        do_store(4'd15, 32'hA0B0C00F);
        chk("store_stall_cycles", 32'(last_stalls), 32'd6);
        do_store(4'd0, 32'hA0B0C000);

        // Multi-block: 18 words fill a block, the 19th waits out the permutation.
        ready_lat = 3; perm_lat = 4;
        do_head(32'h41424344);
        do_store(4'd2, 32'h0);
        for (int k = 0; k < 16; k++) do_data(32'h10203040 + 32'(k));
        @(negedge clk);
        chk("multi_not_full", 32'(blk_valid), 32'd0);
        step();
        do_data(32'hCAFEF00D);
        @(negedge clk);
        chk("multi_valid", 32'(blk_valid), 32'd1);
        chk("multi_last", 32'(blk_last), 32'd0);
        step();
        do_data(32'h31323334);
        chk("multi_stall_cycles", 32'(last_stalls), 32'd8);
        do_tail(2'd2, 32'h58590000);
        do_store(4'd3, 32'hA0B0C003);

        // Partial last word filling the final rate byte.
        ready_lat = 2; perm_lat = 3;
        do_head(32'h00010203);
        for (int k = 0; k < 16; k++) do_data(32'h55AA0000 + 32'(k));
        do_tail(2'd3, 32'h41424300);
        @(negedge clk);
        chk("partial_byte68", 32'(blk_data[8*68 +: 8]), 32'h41);
        chk("partial_byte69", 32'(blk_data[8*69 +: 8]), 32'h42);
        chk("partial_byte70", 32'(blk_data[8*70 +: 8]), 32'h43);
        chk("partial_byte71", 32'(blk_data[8*71 +: 8]), 32'h86);
        step();
        do_store(4'd7, 32'hA0B0C007);

        // HEAD presented while a block is offered.
        ready_lat = 2; perm_lat = 1;
        do_head(32'h01020304);
        for (int k = 0; k < 17; k++) do_data(32'h77000000 + 32'(k));
        @(negedge clk);
        chk("headsend_valid", 32'(blk_valid), 32'd1);
        step();
        do_head(32'h11223344);
        chk("headsend_stall_cycles", 32'(last_stalls), 32'd4);
        for (int k = 0; k < 16; k++) do_data(32'h88000000 + 32'(k));
        @(negedge clk);
        chk("headsend_count_16", 32'(blk_valid), 32'd0);
        step();
        do_data(32'h99999999);
        @(negedge clk);
        chk("headsend_count_full", 32'(blk_valid), 32'd1);
        step();
        do_tail(2'd0, 32'h0);
        do_store(4'd1, 32'hA0B0C001);

        // Reset during a permutation.
        core_en = 0;
        do_head(32'hDEADBEEF);
        for (int k = 0; k < 17; k++) do_data(32'h33000000 + 32'(k));
        blk_ready = 1;
        step();
        blk_ready = 0;
        cust5_valid = 1; cust5_op = OP_DATA; operand_a = 32'h12345678;
        @(negedge clk);
        chk("perm_stall", 32'(stall), 32'd1);
        #1 rst = 0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_blk_valid", 32'(blk_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1;
        cust5_valid = 0; cust5_op = 0; operand_a = 0;
        cur.delete();
        do_store(4'd15, 32'h0);

        step();
        chk("blk_queue_empty", 32'(exp_blk.size()), 32'd0);
        chk("store_queue_empty", 32'(exp_res.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
